ram_param_clr: RTL and testbench
================================

// Module: ram_param_clr
// PURPOSE
//  Parametrised single-port synchronous RAM. Successor to the fixed 8-bit RAM.
//  Adds configurable width and depth, byte-enable writes, registered read with a valid strobe,
//  a selectable read-during-write mode, and a hardware clear FSM that sweeps the array after reset
//  or on request. Serves as the general storage block behind register files and buffers.
// PARAMETERS
//  WIDTH    16  data width in bits; must be a multiple of 8 (NBE = WIDTH/8)
//  DEPTH    12  number of words; need not be a power of 2 (AW = $clog2(DEPTH), min 1)
//  RD_MODE  0   same-address read+write: 0 = read-first (old data), 1 = write-first (merged new data)
//  CLR_VAL  0   WIDTH-bit value written to every word by the clear sweep
// PORTS
//  clk       in   1      sole clock, rising edge
//  rst       in   1      asynchronous, active-low reset
//  wr_co     in   1      write command
//  rd_co     in   1      read command
//  addr      in   AW     word address, shared by read and write
//  data      in   WIDTH  write data
//  be        in   NBE    byte enables; be[i] gates data[8i+7:8i]
//  clr       in   1      clear request, sampled in IDLE only
//  out       out  WIDTH  registered read data
//  rd_valid  out  1      1-cycle strobe: out updated this cycle
//  busy      out  1      clear sweep in progress; commands not accepted
//  err       out  1      1-cycle strobe: command rejected (busy or addr >= DEPTH)
// BEHAVIOUR
//  Reset (rst=0, async)
//   - out=0, rd_valid=0, err=0, busy=1.
//   - state=CLEAR, clr_ptr=0.
//   - Array contents are not reset asynchronously; the sweep initialises them.
//  FSM states
//   - CLEAR: each clock writes CLR_VAL to mem[clr_ptr] and increments clr_ptr.
//     The write at clr_ptr==DEPTH-1 moves to IDLE; busy=0 from the next cycle.
//     busy is therefore high for exactly DEPTH clocks after reset release.
//     clr is ignored in CLEAR (no restart).
//   - IDLE: clr=1 -> CLEAR, clr_ptr=0, busy=1 next cycle. Commands in the same cycle as clr still execute.
//   - rst low mid-sweep aborts; the sweep restarts from 0.
//  Command gating
//   - Any wr_co/rd_co while busy=1 is dropped, and err=1 on the next cycle.
//  Write (IDLE, wr_co=1, addr<DEPTH)
//   - At the edge, mem[addr] byte i <= data byte i where be[i]=1.
//   - be=0 is a legal no-op write.
//  Read (IDLE, rd_co=1, addr<DEPTH)
//   - Latency 1: next cycle out=mem[addr], rd_valid=1.
//   - Otherwise rd_valid=0 and out holds its last value.
//  Read+write at the same address, same cycle
//   - RD_MODE=0: out = pre-write word.
//   - RD_MODE=1: out = word after byte-enable merge.
//  Out of range (addr >= DEPTH)
//   - Write dropped, no array change.
//   - Read gives out=0 with rd_valid=1.
//   - Either command sets err=1 next cycle. err is a single strobe when both commands are bad.
//  Width rules
//   - addr is AW bits, compared unsigned against DEPTH.
//   - clr_ptr is AW bits and never wraps past DEPTH-1.
//  Outputs are registered; there are no combinational paths from inputs to outputs.
// STRUCTURE
//  ram_pkg
//   - localparams RD_FIRST=0, WR_FIRST=1.
//   - State encoding S_CLEAR=1'b0, S_IDLE=1'b1.
//   - Function nbe(width) returning width/8.
//  Sub-module ram_clr_fsm
//   - Owns state, clr_ptr and busy.
//   - Outputs clr_we and clr_addr, muxed ahead of the array write port.
//  Top level: array, byte-merge, read register, err logic.
// TESTING (WIDTH=16, DEPTH=12 unless noted)
//  1. Release rst, idle -> busy=1 for exactly 12 clocks, then 0.
//     Read every address -> out=16'h0000 with rd_valid=1 on each.
//  2. After clear, write addr 3 data 16'hA55A be=2'b11.
//     Then write addr 3 data 16'h1234 be=2'b01, read addr 3 -> out=16'hA534 one cycle after rd_co.
//  3. Same-cycle wr_co+rd_co at addr 5, old 16'h1111, new 16'h2222 be=11.
//     RD_MODE=0 -> out=16'h1111; RD_MODE=1 -> out=16'h2222.
//  4. Write addr 12 (out of range) -> err=1 for 1 cycle, array unchanged.
//     Read addr 15 -> out=0, rd_valid=1, err=1.
//  5. Assert clr in IDLE, then drive wr_co/rd_co during the sweep.
//     Expect busy=1 for 12 clocks, err on each command, rd_valid=0, all words 0 afterwards.
//  6. Pull rst low at sweep cycle 6.
//     Expect out/rd_valid/err = 0 immediately and a full 12-clock sweep after release.

Source files
------------

// File: rtl/ram_param_clr_pkg.sv
// Shared constants, state encoding and helpers for the parametrised clearable RAM.
// Imported by the clear FSM and the RAM top level.
package ram_pkg;

  localparam int RD_FIRST = 0;
  localparam int WR_FIRST = 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_IDLE  = 1'b1
  } state_e;

  function automatic int nbe(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_param_clr_fsm.sv
// Clear sequencer: sweeps every word once after reset or on request, and reports
// busy while the sweep owns the array write port.
module ram_clr_fsm
  import ram_pkg::*;
#(
  parameter int DEPTH = 12,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  state_e        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_CLEAR;
      clr_ptr_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
    end
  end

  // The pointer parks at zero on the last sweep write so it never passes DEPTH-1.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    if (state_q == S_CLEAR) begin
      if (clr_ptr_q == LAST_ADDR) begin
        state_d   = S_IDLE;
        clr_ptr_d = '0;
      end else begin
        clr_ptr_d = clr_ptr_q + 1'b1;
      end
    end else if (clr) begin
      state_d   = S_CLEAR;
      clr_ptr_d = '0;
    end
  end

  assign busy     = (state_q == S_CLEAR);
  assign clr_we   = busy;
  assign clr_addr = clr_ptr_q;

endmodule

// File: rtl/ram_param_clr.sv
// Parametrised single-port RAM with byte enables, registered read, selectable
// read-during-write behaviour and a hardware clear sweep.
module ram_param_clr
  import ram_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter int               DEPTH   = 12,
  parameter int               RD_MODE = RD_FIRST,
  parameter logic [WIDTH-1:0] CLR_VAL = '0,
  localparam int              NBE     = nbe(WIDTH),
  localparam int              AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_co,
  input  logic             rd_co,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] data,
  input  logic [NBE-1:0]   be,
  input  logic             clr,
  output logic [WIDTH-1:0] out,
  output logic             rd_valid,
  output logic             busy,
  output logic             err
);

  localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  logic             clr_we;
  logic [AW-1:0]    clr_addr;
  logic             addr_ok;
  logic [AW-1:0]    rd_idx;
  logic             wr_ok;
  logic             rd_go;
  logic [WIDTH-1:0] old_word;
  logic [WIDTH-1:0] merged_word;

  logic [WIDTH-1:0] out_q, out_d;
  logic             rd_valid_q, rd_valid_d;
  logic             err_q, err_d;

  ram_clr_fsm #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clr_fsm (
    .clk      (clk),
    .rst      (rst),
    .clr      (clr),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  // Out-of-range addresses are steered to word 0 for the lookup only; they never write.
  assign addr_ok = ({1'b0, addr} < DEPTH_W);
  assign rd_idx  = addr_ok ? addr : '0;
  assign wr_ok   = wr_co && !busy && addr_ok;
  assign rd_go   = rd_co && !busy;

  always_comb begin
    old_word    = mem[rd_idx];
    merged_word = old_word;
    for (int i = 0; i < NBE; i++) begin
      if (be[i]) begin
        merged_word[8*i +: 8] = data[8*i +: 8];
      end
    end
  end

  // The sweep has priority on the write port; commands are already gated off by busy.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLR_VAL;
    end else if (wr_ok) begin
      mem[rd_idx] <= merged_word;
    end
  end

  always_comb begin
    out_d      = out_q;
    rd_valid_d = 1'b0;
    err_d      = (wr_co || rd_co) && (busy || !addr_ok);
    if (rd_go) begin
      rd_valid_d = 1'b1;
      if (!addr_ok) begin
        out_d = '0;
      end else if (RD_MODE == WR_FIRST && wr_ok) begin
        out_d = merged_word;
      end else begin
        out_d = old_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q      <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      out_q      <= out_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign out      = out_q;
  assign rd_valid = rd_valid_q;
  assign err      = err_q;

endmodule

// File: tb/tb_ram_param_clr.sv
// Directed bench for ram_param_clr: a read-first and a write-first instance share
// one stimulus stream and are checked against hand-computed values.
module tb_ram_param_clr;

  localparam int WIDTH = 16;
  localparam int DEPTH = 12;
  localparam int AW    = 4;
  localparam int NBE   = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_co;
  logic             rd_co;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] data;
  logic [NBE-1:0]   be;
  logic             clr;

  logic [WIDTH-1:0] out_rf, out_wf;
  logic             rv_rf, rv_wf;
  logic             busy_rf, busy_wf;
  logic             err_rf, err_wf;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  ram_param_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_MODE(0), .CLR_VAL(16'h0000)) u_rf (
    .clk(clk), .rst(rst), .wr_co(wr_co), .rd_co(rd_co), .addr(addr), .data(data),
    .be(be), .clr(clr), .out(out_rf), .rd_valid(rv_rf), .busy(busy_rf), .err(err_rf)
  );

  ram_param_clr #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RD_MODE(1), .CLR_VAL(16'h0000)) u_wf (
    .clk(clk), .rst(rst), .wr_co(wr_co), .rd_co(rd_co), .addr(addr), .data(data),
    .be(be), .clr(clr), .out(out_wf), .rd_valid(rv_wf), .busy(busy_wf), .err(err_wf)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Both instances must agree on everything except the read-during-write result.
  task automatic check_both(input string tag, input logic [WIDTH-1:0] exp_out,
                            input logic exp_rv, input logic exp_busy, input logic exp_err);
    check_output({tag, "_out_rf"}, 32'(out_rf), 32'(exp_out));
    check_output({tag, "_out_wf"}, 32'(out_wf), 32'(exp_out));
    check_output({tag, "_rv"}, {30'd0, rv_rf, rv_wf}, {30'd0, exp_rv, exp_rv});
    check_output({tag, "_busy"}, {30'd0, busy_rf, busy_wf}, {30'd0, exp_busy, exp_busy});
    check_output({tag, "_err"}, {30'd0, err_rf, err_wf}, {30'd0, exp_err, exp_err});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_co = 1'b0;
    rd_co = 1'b0;
    clr   = 1'b0;
    addr  = '0;
    data  = '0;
    be    = '0;
  endtask

  task automatic count_sweep(input string tag);
    n = 0;
    while (busy_rf && n < 50) begin
      step();
      n++;
    end
    check_output(tag, 32'(n), 32'd12);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < DEPTH; a++) begin
      rd_co = 1'b1;
      addr  = AW'(a);
      step();
      check_both(tag, 16'h0000, 1'b1, 1'b0, 1'b0);
    end
    rd_co = 1'b0;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b0;
    #23;
    check_both("reset", 16'h0000, 1'b0, 1'b1, 1'b0);

    // 1: sweep after reset release, then every word reads back zero
    @(posedge clk);
    #1;
    rst = 1'b1;
    count_sweep("sweep_len_reset");
    read_all_zero("post_reset_read");

    // 2: byte-enabled merge
    wr_co = 1'b1; addr = 4'd3; data = 16'hA55A; be = 2'b11;
    step();
    data = 16'h1234; be = 2'b01;
    step();
    wr_co = 1'b0; rd_co = 1'b1;
    step();
    check_both("merge_read", 16'hA534, 1'b1, 1'b0, 1'b0);
    rd_co = 1'b0;
    step();
    check_both("read_hold", 16'hA534, 1'b0, 1'b0, 1'b0);

    // 3: same-cycle read and write at one address
    wr_co = 1'b1; addr = 4'd5; data = 16'h1111; be = 2'b11;
    step();
    rd_co = 1'b1; data = 16'h2222;
    step();
    check_output("rdw_rf", 32'(out_rf), 32'h1111);
    check_output("rdw_wf", 32'(out_wf), 32'h2222);
    data = 16'h33CC; be = 2'b10;
    step();
    check_output("rdw_be_rf", 32'(out_rf), 32'h2222);
    check_output("rdw_be_wf", 32'(out_wf), 32'h3322);
    wr_co = 1'b0;
    step();
    check_both("rdw_after", 16'h3322, 1'b1, 1'b0, 1'b0);
    rd_co = 1'b0;

    // 4: out-of-range commands
    wr_co = 1'b1; addr = 4'd12; data = 16'hFFFF; be = 2'b11;
    step();
    check_both("oor_wr", 16'h3322, 1'b0, 1'b0, 1'b1);
    wr_co = 1'b0;
    step();
    check_both("oor_wr_clear", 16'h3322, 1'b0, 1'b0, 1'b0);
    rd_co = 1'b1; addr = 4'd0;
    step();
    check_both("oor_wr_word0", 16'h0000, 1'b1, 1'b0, 1'b0);
    addr = 4'd3;
    step();
    check_both("oor_wr_word3", 16'hA534, 1'b1, 1'b0, 1'b0);
    addr = 4'd15;
    step();
    check_both("oor_rd", 16'h0000, 1'b1, 1'b0, 1'b1);
    wr_co = 1'b1; addr = 4'd13;
    step();
    check_both("oor_both", 16'h0000, 1'b1, 1'b0, 1'b1);
    wr_co = 1'b0; rd_co = 1'b0;
    step();
    check_both("oor_both_single", 16'h0000, 1'b0, 1'b0, 1'b0);

    // 5: requested clear, with a read issued alongside clr and commands during the sweep
    clr = 1'b1; rd_co = 1'b1; addr = 4'd3;
    step();
    check_both("clr_cmd", 16'hA534, 1'b1, 1'b1, 1'b0);
    clr = 1'b0;
    n = 0;
    while (busy_rf && n < 50) begin
      wr_co = 1'b1; rd_co = 1'b1; addr = 4'd4; data = 16'hFFFF; be = 2'b11;
      step();
      n++;
      check_output("sweep_err", {31'd0, err_rf & err_wf}, 32'd1);
      check_output("sweep_rv", {30'd0, rv_rf, rv_wf}, 32'd0);
    end
    check_output("sweep_len_clr", 32'(n), 32'd12);
    idle_inputs();
    check_both("sweep_out_hold", 16'hA534, 1'b0, 1'b0, 1'b1);
    read_all_zero("post_clr_read");

    // 6: reset in the middle of a sweep
    wr_co = 1'b1; addr = 4'd2; data = 16'hBEEF; be = 2'b11;
    step();
    wr_co = 1'b0; rd_co = 1'b1;
    step();
    check_both("pre_abort_read", 16'hBEEF, 1'b1, 1'b0, 1'b0);
    rd_co = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0;
    repeat (5) step();
    rd_co = 1'b1;
    step();
    rd_co = 1'b0;
    check_both("pre_abort_err", 16'hBEEF, 1'b0, 1'b1, 1'b1);
    rst = 1'b0;
    #1;
    check_both("abort_reset", 16'h0000, 1'b0, 1'b1, 1'b0);
    step();
    step();
    rst = 1'b1;
    count_sweep("sweep_len_abort");
    rd_co = 1'b1; addr = 4'd2;
    step();
    check_both("post_abort_word2", 16'h0000, 1'b1, 1'b0, 1'b0);
    rd_co = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
